// File: rtl/game_pkg.sv
// Shared types and widths for the round manager.
// Score feature is guarded by GAME_ROUND_SCORE_EN.
package game_pkg;
  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 3;
  localparam int SCORE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_WIN_SHOW,
    S_LOSE_SHOW,
    S_OVER
  } state_e;
endpackage

// File: rtl/game_round_manager_frame_timer.sv
// Counts frame ticks while a banner is up.
// done fires on the tick that reaches SHOW_FRAMES.
module frame_timer #(
  parameter int SHOW_FRAMES = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic done
);
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign done = tick && !clear &&
                (({1'b0, cnt_q} + 9'd1) == 9'(SHOW_FRAMES));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/game_round_manager.sv
// Round/lives/level/score sequencer for the frog game.
// Define GAME_ROUND_SCORE_EN to build the score register.
module game_round_manager
  import game_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int SHOW_FRAMES = 120,
  parameter int LEVEL_MAX   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               win,
  input  logic               lose,
  input  logic               start_key,
  input  logic               frame_tick,
  output logic               round_restart,
  output logic               show_win,
  output logic               show_lose,
  output logic               game_over,
  output logic               playing,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic [SCORE_W-1:0] score
);
  state_e             state_q, state_d;
  logic               start_q;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               rr_q, rr_d;
  logic               sw_q, sl_q, go_q, pl_q;
  logic               start_evt;
  logic               banner;
  logic               done;

  assign start_evt = start_key && !start_q;
  assign banner = (state_q == S_WIN_SHOW) ||
                  (state_q == S_LOSE_SHOW);

  frame_timer #(
    .SHOW_FRAMES(SHOW_FRAMES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(!banner),
    .tick (frame_tick),
    .done (done)
  );

`ifdef GAME_ROUND_SCORE_EN
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   score_sum;

  // Points use the level before this win's increment.
  assign score_sum = {1'b0, score_q} +
                     {{(SCORE_W-LEVEL_W+1){1'b0}}, level_q} +
                     9'd1;
`endif

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    rr_d    = 1'b0;
`ifdef GAME_ROUND_SCORE_EN
    score_d = score_q;
`endif
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_evt) begin
          state_d = S_PLAY;
          lives_d = LIVES_W'(LIVES_INIT);
          level_d = '0;
          rr_d    = 1'b1;
`ifdef GAME_ROUND_SCORE_EN
          score_d = '0;
`endif
        end
      end
      S_PLAY: begin
        if (lose) begin
          lives_d = lives_q - 1'b1;
          state_d = (lives_q == 2'd1) ? S_OVER : S_LOSE_SHOW;
        end else if (win) begin
          state_d = S_WIN_SHOW;
          if (level_q < LEVEL_W'(LEVEL_MAX)) begin
            level_d = level_q + 1'b1;
          end
`ifdef GAME_ROUND_SCORE_EN
          score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
`endif
        end
      end
      S_WIN_SHOW, S_LOSE_SHOW: begin
        if (done) begin
          state_d = S_PLAY;
          rr_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      lives_q <= '0;
      level_q <= '0;
      rr_q    <= 1'b0;
      sw_q    <= 1'b0;
      sl_q    <= 1'b0;
      go_q    <= 1'b0;
      pl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_key;
      lives_q <= lives_d;
      level_q <= level_d;
      rr_q    <= rr_d;
      sw_q    <= (state_d == S_WIN_SHOW);
      sl_q    <= (state_d == S_LOSE_SHOW);
      go_q    <= (state_d == S_OVER);
      pl_q    <= (state_d == S_PLAY);
    end
  end

`ifdef GAME_ROUND_SCORE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end
  assign score = score_q;
`else
  assign score = '0;
`endif

  assign round_restart = rr_q;
  assign show_win      = sw_q;
  assign show_lose     = sl_q;
  assign game_over     = go_q;
  assign playing       = pl_q;
  assign lives         = lives_q;
  assign level         = level_q;
endmodule

// File: tb/tb_game_round_manager.sv
// Directed bench for game_round_manager.
// Banner length 2 frames; score expected 0 unless GAME_ROUND_SCORE_EN.
module tb_game_round_manager;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       win = 1'b0;
  logic       lose = 1'b0;
  logic       start_key = 1'b0;
  logic       frame_tick = 1'b0;
  logic       round_restart, show_win, show_lose, game_over, playing;
  logic [1:0] lives;
  logic [2:0] level;
  logic [7:0] score;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  game_round_manager #(
    .LIVES_INIT (3),
    .SHOW_FRAMES(2),
    .LEVEL_MAX  (7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .win          (win),
    .lose         (lose),
    .start_key    (start_key),
    .frame_tick   (frame_tick),
    .round_restart(round_restart),
    .show_win     (show_win),
    .show_lose    (show_lose),
    .game_over    (game_over),
    .playing      (playing),
    .lives        (lives),
    .level        (level),
    .score        (score)
  );

  wire [17:0] obs = {round_restart, show_win, show_lose, game_over,
                     playing, lives, level, score};

  function automatic logic [17:0] pk(input logic rr, sw, sl, go, pl,
                                     input logic [1:0] lv,
                                     input logic [2:0] le,
                                     input int sc);
`ifdef GAME_ROUND_SCORE_EN
    logic [7:0] s = 8'(sc);
`else
    logic [7:0] s = 8'd0;
`endif
    return {rr, sw, sl, go, pl, lv, le, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    win = 1'b0;
    lose = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (obs !== pk(0,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL reset_state got %h want %h", obs, pk(0,0,0,0,0,0,0,0));
    end
    reset = 1'b0;
    lose = 1'b1;
    step();
    win = 1'b1;
    step();
    checks++;
    if (obs !== pk(0,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL idle_ignore got %h want %h", obs, pk(0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_start();
    start_key = 1'b1;
    step();
    checks++;
    if (obs !== pk(1,0,0,0,1,3,0,0)) begin
      errors++;
      $display("FAIL start got %h want %h", obs, pk(1,0,0,0,1,3,0,0));
    end
    step();
    checks++;
    if (obs !== pk(0,0,0,0,1,3,0,0)) begin
      errors++;
      $display("FAIL start_rr_once got %h want %h", obs, pk(0,0,0,0,1,3,0,0));
    end
    start_key = 1'b0;
    step();
  endtask

  task automatic do_win(input logic [1:0] lv, input logic [2:0] le,
                        input int sc);
    logic [17:0] e;
    win = 1'b1;
    step();
    e = pk(0,1,0,0,0,lv,le,sc);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL win_enter got %h want %h", obs, e);
    end
    frame_tick = 1'b1;
    step();
    step();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL win_hold got %h want %h", obs, e);
    end
    frame_tick = 1'b1;
    step();
    e = pk(1,0,0,0,1,lv,le,sc);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL win_done got %h want %h", obs, e);
    end
    step();
    e = pk(0,0,0,0,1,lv,le,sc);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL win_rr_once got %h want %h", obs, e);
    end
  endtask

  task automatic do_lose(input logic [1:0] lv, input logic [2:0] le,
                         input int sc);
    logic [17:0] e;
    lose = 1'b1;
    step();
    if (lv == 2'd0) begin
      e = pk(0,0,0,1,0,0,le,sc);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL over got %h want %h", obs, e);
      end
    end else begin
      e = pk(0,0,1,0,0,lv,le,sc);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL lose_enter got %h want %h", obs, e);
      end
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b1;
      step();
      e = pk(1,0,0,0,1,lv,le,sc);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL lose_done got %h want %h", obs, e);
      end
      step();
    end
  endtask

  task automatic test_win();
    do_win(3, 1, 1);
    do_win(3, 2, 3);
    do_win(3, 3, 6);
  endtask

  task automatic test_lose();
    do_lose(2, 3, 6);
    do_lose(1, 3, 6);
    do_lose(0, 3, 6);
    start_key = 1'b1;
    step();
    checks++;
    if (obs !== pk(1,0,0,0,1,3,0,0)) begin
      errors++;
      $display("FAIL restart got %h want %h", obs, pk(1,0,0,0,1,3,0,0));
    end
    start_key = 1'b0;
    step();
  endtask

  task automatic test_same_cycle();
    logic [17:0] e;
    win = 1'b1;
    lose = 1'b1;
    step();
    e = pk(0,0,1,0,0,2,0,0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL win_lose_prio got %h want %h", obs, e);
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b1;
    step();
    win = 1'b1;
    step();
    win = 1'b1;
    step();
    lose = 1'b1;
    step();
    e = pk(0,1,0,0,0,2,1,1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL win_in_banner got %h want %h", obs, e);
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b1;
    step();
    step();
  endtask

  task automatic test_saturation();
    int lvl = 1;
    int sc = 1;
    for (int i = 0; i < 36; i++) begin
      sc = (sc + lvl + 1 > 255) ? 255 : sc + lvl + 1;
      lvl = (lvl < 7) ? lvl + 1 : 7;
      do_win(2, 3'(lvl), sc);
    end
    checks++;
    if (obs !== pk(0,0,0,0,1,2,7,255)) begin
      errors++;
      $display("FAIL saturate got %h want %h", obs, pk(0,0,0,0,1,2,7,255));
    end
  endtask

  task automatic test_reset_mid();
    lose = 1'b1;
    step();
    frame_tick = 1'b1;
    step();
    reset = 1'b1;
    step();
    checks++;
    if (obs !== pk(0,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL reset_mid got %h want %h", obs, pk(0,0,0,0,0,0,0,0));
    end
    reset = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    checks++;
    if (obs !== pk(0,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL post_reset_idle got %h want %h", obs, pk(0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_held_key();
    start_key = 1'b1;
    step();
    step();
    step();
    checks++;
    if (obs !== pk(0,0,0,0,1,3,0,0)) begin
      errors++;
      $display("FAIL held_in_play got %h want %h", obs, pk(0,0,0,0,1,3,0,0));
    end
    do_lose(2, 0, 0);
    do_lose(1, 0, 0);
    do_lose(0, 0, 0);
    step();
    step();
    checks++;
    if (obs !== pk(0,0,0,1,0,0,0,0)) begin
      errors++;
      $display("FAIL held_in_over got %h want %h", obs, pk(0,0,0,1,0,0,0,0));
    end
    start_key = 1'b0;
    step();
    start_key = 1'b1;
    step();
    checks++;
    if (obs !== pk(1,0,0,0,1,3,0,0)) begin
      errors++;
      $display("FAIL new_edge got %h want %h", obs, pk(1,0,0,0,1,3,0,0));
    end
    start_key = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_start();
    test_win();
    test_lose();
    test_same_cycle();
    test_saturation();
    test_reset_mid();
    test_held_key();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
